serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 116 +++++++++++
 tb/tb_serial_subtractor.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - b_in one bit per clock, LSB first,
// through a single full-subtractor cell with a start/done handshake.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             b_out
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             load;
  logic             step;
  logic             last;
  logic             diff_bit;
  logic             br_next;

  // Next-state logic and the full-subtractor cell.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    last       = (cnt == CW'(WIDTH - 1));
    diff_bit   = a_sh[0] ^ b_sh[0] ^ br;
    br_next    = (~a_sh[0] & b_sh[0]) | (~a_sh[0] & br) | (b_sh[0] & br);
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; busy/done are registered decodes of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == RUN);
      done  <= (state_next == DONE);
    end
  end

  // Operand shifters, borrow, bit counter and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      d     <= '0;
      b_out <= 1'b0;
    end else if (load) begin
      a_sh <= a;
      b_sh <= b;
      br   <= b_in;
      cnt  <= '0;
    end else if (step) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      res  <= {diff_bit, res[WIDTH-1:1]};
      br   <= br_next;
      if (last) begin
        // Final bit goes straight into d so the result is complete on entry to DONE.
        d     <= {diff_bit, res[WIDTH-1:1]};
        b_out <= br_next;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4): directed vectors,
// reset behaviour, start-while-busy, exhaustive sweep and adder round-trip.
module tb_serial_subtractor;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             b_out;

  int checks;
  int failures;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .b_out (b_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one operation from IDLE/DONE and check latency, busy length and result.
  task automatic run_op(input string tag, input logic [3:0] av, input logic [3:0] bv,
                        input logic bi, input logic [3:0] exp_d, input logic exp_bo);
    int n;
    int busy_n;
    @(negedge clk);
    a = av; b = bv; b_in = bi; start = 1'b1;
    n = 0;
    busy_n = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (busy) busy_n++;
    end while (!done && n < 20);
    check({tag, "_lat"}, 32'(n), 32'(WIDTH + 1));
    check({tag, "_busy"}, 32'(busy_n), 32'(WIDTH));
    check({tag, "_d"}, 32'(d), 32'(exp_d));
    check({tag, "_bo"}, 32'(b_out), 32'(exp_bo));
  endtask

  initial begin
    int n;
    logic [4:0] tmp;
    logic [4:0] sum;
    checks   = 0;
    failures = 0;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    b_in  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_d", 32'(d), 32'd0);
    check("rst_bo", 32'(b_out), 32'd0);
    rst = 1'b0;

    // Basic, then done must drop after one cycle while d holds.
    run_op("basic", 4'd5, 4'd3, 1'b0, 4'b0010, 1'b0);
    @(negedge clk);
    check("basic_pulse", 32'(done), 32'd0);
    check("basic_hold", 32'(d), 32'b0010);

    run_op("under1", 4'd3, 4'd5, 1'b0, 4'b1110, 1'b1);
    run_op("under2", 4'd0, 4'd0, 1'b1, 4'b1111, 1'b1);
    run_op("equal", 4'd15, 4'd15, 1'b0, 4'b0000, 1'b0);

    // Start held through RUN with operands changed mid-operation.
    @(negedge clk);
    a = 4'd7; b = 4'd2; b_in = 1'b0; start = 1'b1;
    repeat (2) @(negedge clk);
    a = 4'd9; b = 4'd1;
    n = 2;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("sdr_lat1", 32'(n), 32'(WIDTH + 1));
    check("sdr_d1", 32'(d), 32'b0101);
    check("sdr_bo1", 32'(b_out), 32'd0);
    n = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (n == 1) check("sdr_hold", 32'(d), 32'b0101);
    end while (!done && n < 20);
    check("sdr_lat2", 32'(n), 32'(WIDTH + 1));
    check("sdr_d2", 32'(d), 32'b1000);
    check("sdr_bo2", 32'(b_out), 32'd0);

    // Asynchronous reset mid-RUN.
    @(negedge clk);
    a = 4'd9; b = 4'd3; b_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_d", 32'(d), 32'd0);
    check("mrst_bo", 32'(b_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) n++;
    end
    check("mrst_idle", 32'(n), 32'd0);
    run_op("after_rst", 4'd12, 4'd4, 1'b0, 4'b1000, 1'b0);

    // Exhaustive sweep against an extended-width reference, plus adder round-trip.
    for (int v = 0; v < 512; v++) begin
      logic [3:0] av;
      logic [3:0] bv;
      logic       bi;
      {av, bv, bi} = 9'(v);
      tmp = {1'b0, av} - {1'b0, bv} - 5'(bi);
      run_op("exh", av, bv, bi, tmp[3:0], tmp[4]);
      sum = {1'b0, av} + {1'b0, bv} + 5'(bi);
      if (!sum[4]) begin
        run_op("rtrip", sum[3:0], bv, bi, av, 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
